// File: rtl/melody_seq.sv
// Plays a fixed 16-entry song table as (octave, note) codes for a buzzer stage,
// with a silent gap after every note so repeated notes stay audible as separate notes.
module melody_seq #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000   // must be at least 1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [1:0] tone,
  output logic [2:0] unable,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx
);

  localparam int LONGEST = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(LONGEST + 1);
  localparam logic [CW-1:0] GAP_LEN = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  // Entry layout: {tone[1:0], note[2:0], beats_m1[1:0]}; tone 2'b00 marks the end.
  function automatic logic [6:0] song(input logic [3:0] i);
    if (i <= 4'd6)      song = {2'b11, i[2:0], 2'd0};
    else if (i == 4'd7) song = {2'b11, 3'd0, 2'd1};
    else                song = 7'd0;
  endfunction

  // Counters load length-1 and count down to zero.
  function automatic logic [CW-1:0] note_len(input logic [1:0] beats_m1);
    note_len = CW'((int'(beats_m1) + 1) * BEAT_CYCLES - 1);
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    nxt;
  logic [6:0]    nxt_e;
  logic [6:0]    first_e;

  assign nxt     = idx + 4'd1;
  assign nxt_e   = song(nxt);
  assign first_e = song(4'd0);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state  <= IDLE;
      tone   <= 2'b00;
      unable <= 3'b111;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= 4'd0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= NOTE;
            idx    <= 4'd0;
            tone   <= first_e[6:5];
            unable <= first_e[4:2];
            busy   <= 1'b1;
            cnt    <= note_len(first_e[1:0]);
          end
        end
        NOTE: begin
          if (stop) begin
            state  <= IDLE;
            tone   <= 2'b00;
            unable <= 3'b111;
            busy   <= 1'b0;
            idx    <= 4'd0;
            cnt    <= '0;
          end else if (cnt == '0) begin
            state  <= GAP;
            unable <= 3'b111;
            cnt    <= GAP_LEN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (stop) begin
            state  <= IDLE;
            tone   <= 2'b00;
            unable <= 3'b111;
            busy   <= 1'b0;
            idx    <= 4'd0;
            cnt    <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (idx == 4'd15 || nxt_e[6:5] == 2'b00) begin
            done <= 1'b1;
            idx  <= 4'd0;
            if (loop) begin
              state  <= NOTE;
              tone   <= first_e[6:5];
              unable <= first_e[4:2];
              cnt    <= note_len(first_e[1:0]);
            end else begin
              state  <= IDLE;
              tone   <= 2'b00;
              unable <= 3'b111;
              busy   <= 1'b0;
              cnt    <= '0;
            end
          end else begin
            state  <= NOTE;
            idx    <= nxt;
            tone   <= nxt_e[6:5];
            unable <= nxt_e[4:2];
            cnt    <= note_len(nxt_e[1:0]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq: a timeline model predicts every output cycle,
// a negedge monitor pops predictions and compares them with the DUT.
module tb_melody_seq;

  localparam int BEAT = 8;
  localparam int GAPC = 2;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0] tone;
  logic [2:0] unable;
  logic       busy, done;
  logic [3:0] idx;

  melody_seq #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .tone(tone), .unable(unable), .busy(busy), .done(done), .idx(idx)
  );

  always #5 sysclk = ~sysclk;

  // Expected word: {tone[10:9], unable[8:6], busy[5], done[4], idx[3:0]}
  localparam logic [10:0] IDLE_OUT = {2'b00, 3'b111, 1'b0, 1'b0, 4'd0};

  int song_tone  [16];
  int song_note  [16];
  int song_beats [16];

  initial begin
    for (int e = 0; e < 16; e++) begin
      song_tone[e] = 0; song_note[e] = 0; song_beats[e] = 1;
    end
    for (int e = 0; e < 7; e++) begin
      song_tone[e] = 3; song_note[e] = e; song_beats[e] = 1;
    end
    song_tone[7] = 3; song_note[7] = 0; song_beats[7] = 2;
  end

  // Total cycles of one pass through the song (notes plus gaps).
  function automatic int song_len();
    int off = 0;
    for (int e = 0; e < 16; e++) begin
      if (song_tone[e] == 0) break;
      off += song_beats[e] * BEAT + GAPC;
    end
    return off;
  endfunction

  // Output k cycles into a pass (k = 1 is the first cycle of entry 0).
  function automatic logic [10:0] play_out(int k);
    int off = 0;
    for (int e = 0; e < 16; e++) begin
      int d;
      if (song_tone[e] == 0) break;
      d = song_beats[e] * BEAT;
      if (k <= off + d)
        return {2'(song_tone[e]), 3'(song_note[e]), 1'b1, 1'b0, 4'(e)};
      if (k <= off + d + GAPC)
        return {2'(song_tone[e]), 3'b111, 1'b1, 1'b0, 4'(e)};
      off += d + GAPC;
    end
    return IDLE_OUT;
  endfunction

  logic [10:0] exp_q[$];
  bit          playing = 1'b0;
  int          k = 0;

  always @(posedge sysclk) begin : model
    bit          np;
    int          nk;
    bit          fin;
    logic [10:0] e;
    np = playing; nk = k; fin = 1'b0;
    if (rst) np = 1'b0;
    else if (!playing) begin
      if (start && !stop) begin np = 1'b1; nk = 1; end
    end else if (stop) np = 1'b0;
    else begin
      nk = k + 1;
      if (nk == song_len() + 1) begin
        fin = 1'b1;
        if (loop) nk = 1;
        else np = 1'b0;
      end
    end
    e = np ? play_out(nk) : IDLE_OUT;
    if (fin) e[4] = 1'b1;
    exp_q.push_back(e);
    playing <= np;
    k       <= nk;
  end

  int vectors = 0;
  int miscompares = 0;

  always @(negedge sysclk) begin : monitor
    logic [10:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tone, unable, busy, done, idx};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got tone=%b unable=%b busy=%b done=%b idx=%0d, want tone=%b unable=%b busy=%b done=%b idx=%0d",
                 $time, a[10:9], a[8:6], a[5], a[4], a[3:0], e[10:9], e[8:6], e[5], e[4], e[3:0]);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    if ({tone, unable, busy, done, idx} !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL reset state (%s) @%0t: tone=%b unable=%b busy=%b done=%b idx=%0d",
               tag, $time, tone, unable, busy, done, idx);
    end
  endtask

  initial begin
    bit seen_done;
    tick(3);
    chk_idle("power-up");
    rst = 1'b0;
    tick(2);
    // reset mid-note, start held high under reset
    pulse_start(); tick(4);
    rst = 1'b1; start = 1'b1; tick();
    chk_idle("mid-note");
    tick(2);
    rst = 1'b0; start = 1'b0; tick(5);
    // full song with a colliding start while busy
    pulse_start(); tick(2);
    pulse_start();
    seen_done = 1'b0;
    repeat (100) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    if (!seen_done) begin
      miscompares++;
      $display("FAIL wait for done expired @%0t", $time);
    end
    // stop at a random point, then restart
    pulse_start(); tick($urandom_range(1, 85));
    stop = 1'b1; tick(); stop = 1'b0; tick(3);
    pulse_start(); tick(20);
    stop = 1'b1; tick(); stop = 1'b0; tick(3);
    // start and stop together in idle
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick(5);
    // looping playback, then let it finish
    loop = 1'b1; pulse_start(); tick(200);
    loop = 1'b0; tick(100);
    // random storm
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      tick();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    tick(2);
    @(negedge sysclk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 12500000, giving sysclk cycles per beat (0.25 s at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 1250000, giving sysclk cycles of silence inserted after every note.
REQ-003 SHALL have port sysclk, input, 1 bit: single system clock, 50 MHz, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: play request, sampled every cycle.
REQ-006 SHALL have port stop, input, 1 bit: abort request, sampled every cycle.
REQ-007 SHALL have port loop, input, 1 bit: restart the song at its end instead of finishing.
REQ-008 SHALL have port tone, output, 2 bits: octave code to the buzzer stage (2'b11 normal, 2'b10 low, 2'b01 lower, 2'b00 silent).
REQ-009 SHALL have port unable, output, 3 bits: note code to the buzzer stage (3'b000..3'b110 do..xi, 3'b111 rest).
REQ-010 SHALL have port busy, output, 1 bit: high while a song is playing.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at song completion.
REQ-012 SHALL have port idx, output, 4 bits: current song entry index.

Function
REQ-013 SHALL hold a 16-entry constant song table; each entry is {tone[1:0], note[2:0], beats_m1[1:0]}, so a note lasts beats_m1+1 beats.
REQ-014 SHALL fill the table as follows: entries 0-6 are tone 2'b11, notes 3'b000..3'b110 in order, 1 beat each; entry 7 is tone 2'b11, note 3'b000, 2 beats; entry 8 is the end marker (tone 2'b00); entries 9-15 are end markers.
REQ-015 SHALL implement states IDLE, NOTE, GAP.
REQ-016 IDLE: tone=2'b00, unable=3'b111, busy=0; start=1 and stop=0 -> NOTE with idx=0 on the next cycle.
REQ-017 NOTE: tone and unable come from entry idx, busy=1; these values are held for exactly (beats_m1+1)*BEAT_CYCLES cycles, then the state goes to GAP.
REQ-018 GAP: unable=3'b111, tone is held, busy=1; this lasts exactly GAP_CYCLES cycles. The rest code guarantees the buzzer sees a note change before the next note, even when the same note repeats.
REQ-019 At GAP end, the next index is idx+1. If that entry is not an end marker, the state goes to NOTE with the new idx.
REQ-020 At GAP end, if the next entry is an end marker or idx=15 (wrap): with loop=0 -> IDLE, idx=0, done=1 for that one cycle, busy=0 in that cycle.
REQ-021 At GAP end, if the next entry is an end marker or idx=15 (wrap): with loop=1 -> NOTE with idx=0, done=1 for one cycle, busy stays 1.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 stop=1 in NOTE or GAP -> IDLE on the next cycle with IDLE outputs and idx=0; done SHALL NOT be asserted.
REQ-024 If start and stop are both high in the same cycle, stop SHALL win.
REQ-025 Duration counters SHALL be wide enough for 4*BEAT_CYCLES and SHALL NOT wrap within a note.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 SHALL take priority over start, stop and loop.
REQ-028 On the cycle after rst=1 is sampled: state=IDLE, tone=2'b00, unable=3'b111, busy=0, done=0, idx=0, counters cleared.
REQ-029 Reset mid-note SHALL silence the output on the next cycle; play SHALL resume only on a new start.

Verification (BEAT_CYCLES=8, GAP_CYCLES=2, start pulse in cycle T)
REQ-030 Reset: assert rst during NOTE -> next cycle tone=00, unable=111, busy=0, idx=0; hold start high with rst high -> no play.
REQ-031 First note: T+1..T+8 tone=11, unable=000, idx=0, busy=1; T+9..T+10 unable=111; T+11 unable=001, idx=1.
REQ-032 Full song, loop=0: entry 7 holds unable=000 for 16 cycles; done=1 and busy=0 only in cycle T+89; outputs silent after that.
REQ-033 Stop: stop pulse at T+4 -> T+5 unable=111, tone=00, busy=0, done never high; a new start at T+8 -> T+9 unable=000, idx=0.
REQ-034 Collisions: start pulsed at T+3 while busy -> timeline identical to REQ-031; start and stop together in IDLE -> stays IDLE.
REQ-035 Loop: loop=1 -> T+89 done=1, busy=1, idx=0, unable=000; the song repeats with a period of 88 cycles.
